// File: rtl/fifo_write_full_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_write_full_ctrl : async FIFO write-side pointer, full/almost_full logic.
// Optional sticky overflow flag: FIFO_WRITE_OVERFLOW_EN.   Revision 1.0
// ---------------------------------------------------------------------------
module fifo_write_full_ctrl #(
   parameter int DEPTH              = 16,
   parameter int ALMOST_FULL_MARGIN = 2
) (
   input  logic                       write_clock,
   input  logic                       write_reset_n,
   input  logic                       write_enable,
   input  logic [$clog2(DEPTH):0]     read_pointer,
   output logic [$clog2(DEPTH)-1:0]   write_address,
   output logic                       write_strobe,
   output logic [$clog2(DEPTH):0]     write_pointer,
   output logic                       full,
   output logic                       almost_full
`ifdef FIFO_WRITE_OVERFLOW_EN
   ,
   output logic                       overflow
`endif
);

   localparam int c_ADDR_W = $clog2(DEPTH);
   localparam int c_PTR_W  = c_ADDR_W + 1;
   localparam logic [c_PTR_W-1:0] c_AF_LEVEL = c_PTR_W'(DEPTH - ALMOST_FULL_MARGIN);

   logic [c_PTR_W-1:0] rq1_q;
   logic [c_PTR_W-1:0] rq2_q;
   logic [c_PTR_W-1:0] bin_q;
   logic [c_PTR_W-1:0] bin_d;
   logic [c_PTR_W-1:0] gray_q;
   logic [c_PTR_W-1:0] gray_d;
   logic               full_q;
   logic               full_d;
   logic               afull_q;
   logic               afull_d;
   logic [c_PTR_W-1:0] w_rbin;
   logic [c_PTR_W-1:0] w_level;
   logic [c_PTR_W-1:0] w_full_cmp;
   logic               w_accept;

   assign w_accept = write_enable & ~full_q;

   always_ff @(posedge write_clock or negedge write_reset_n) begin
      if (!write_reset_n) begin
         rq1_q <= '0;
         rq2_q <= '0;
      end else begin
         rq1_q <= read_pointer;
         rq2_q <= rq1_q;
      end
   end

   // Gray-to-binary of the synchronized read pointer.
   always_comb begin
      w_rbin             = '0;
      w_rbin[c_PTR_W-1]  = rq2_q[c_PTR_W-1];
      for (int i = c_PTR_W - 2; i >= 0; i--) begin
         w_rbin[i] = w_rbin[i+1] ^ rq2_q[i];
      end
   end

   // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
   assign w_full_cmp = {~rq2_q[c_ADDR_W:c_ADDR_W-1], rq2_q[c_ADDR_W-2:0]};

   always_comb begin
      bin_d   = bin_q + c_PTR_W'(w_accept);
      gray_d  = (bin_d >> 1) ^ bin_d;
      w_level = bin_d - w_rbin;
      full_d  = (gray_d == w_full_cmp);
      afull_d = (w_level >= c_AF_LEVEL);
   end

   always_ff @(posedge write_clock or negedge write_reset_n) begin
      if (!write_reset_n) begin
         bin_q   <= '0;
         gray_q  <= '0;
         full_q  <= 1'b0;
         afull_q <= 1'b0;
      end else begin
         bin_q   <= bin_d;
         gray_q  <= gray_d;
         full_q  <= full_d;
         afull_q <= afull_d;
      end
   end

`ifdef FIFO_WRITE_OVERFLOW_EN
   logic overflow_q;
   logic overflow_d;

   assign overflow_d = overflow_q | (write_enable & full_q);

   always_ff @(posedge write_clock or negedge write_reset_n) begin
      if (!write_reset_n) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
      end
   end

   assign overflow = overflow_q;
`endif

   assign write_address = bin_q[c_ADDR_W-1:0];
   assign write_strobe  = w_accept;
   assign write_pointer = gray_q;
   assign full          = full_q;
   assign almost_full   = afull_q;

endmodule
`default_nettype wire
